// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg -- shared definitions for the PS/2 keyboard event unit.
//   PS2_BREAK / PS2_EXT : scan-code prefixes for release and extended keys
//   kbd_state_e         : prefix-decoder states
//   kbd_evt_t           : one decoded key event {ext, brk, code}
//   odd_parity_ok()     : PS/2 frame parity helper
// ---------------------------------------------------------------------------
package kbd_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx -- PS/2 device-to-host frame receiver.
//   clock, resetn       : system clock, synchronous active-low reset
//   ps2_clk, ps2_data   : asynchronous PS/2 lines (3-flop synchronised here)
//   byte_valid          : one-cycle pulse, byte_data holds a checked byte
//   byte_data           : received data byte
//   frame_err           : one-cycle pulse for a bad frame or a watchdog abort
// Parameter TIMEOUT_CYC: idle cycles inside a frame before it is abandoned.
// ---------------------------------------------------------------------------
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]       clk_sync_q;
  logic [2:0]       data_sync_q;
  logic             fall_s;
  logic             frame_ok_s;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             frame_err_q, frame_err_d;

  // Line synchronisers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
    end
  end

  assign fall_s = (clk_sync_q[2:1] == 2'b10);

  // shift_q holds start (bit 0), data LSB-first (bits 8:1), parity (bit 9);
  // the stop bit is still on the synchronised data line at the 11th edge.
  assign frame_ok_s = (shift_q[0] == 1'b0) && (data_sync_q[2] == 1'b1) &&
                      odd_parity_ok(shift_q[8:1], shift_q[9]);

  // Bit collection, frame check and inter-edge watchdog.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmr_d        = tmr_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;
    if (fall_s) begin
      tmr_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_ok_s) begin
          byte_valid_d = 1'b1;
          byte_data_d  = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {data_sync_q[2], shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d   = 4'd0;
        tmr_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end else begin
      tmr_d = '0;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      bit_cnt_q    <= 4'd0;
      shift_q      <= 10'd0;
      tmr_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmr_q        <= tmr_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_kbd_event_unit.sv
// ---------------------------------------------------------------------------
// ps2_kbd_event_unit -- PS/2 keyboard receiver, prefix decoder and event FIFO.
//   clock, resetn        : system clock, synchronous active-low reset
//   ps2_clk, ps2_data    : asynchronous PS/2 lines
//   evt_valid/evt_ready  : show-ahead FIFO handshake, pop on valid && ready
//   evt_code/ext/break   : head event fields
//   press_cnt            : running count of emitted make events (wraps)
//   fifo_level           : FIFO occupancy
//   overflow             : sticky, an event was dropped on a full FIFO
//   frame_err            : one-cycle pulse per rejected/abandoned frame
// Optional build macro KBD_TYPEMATIC_FILTER_EN: suppress auto-repeat makes of
// the currently held key (neither queued nor counted) until its break.
// ---------------------------------------------------------------------------
module ps2_kbd_event_unit
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic [CNT_W-1:0]            press_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic       rx_valid_s;
  logic [7:0] rx_data_s;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clock      (clock),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (rx_valid_s),
    .byte_data  (rx_data_s),
    .frame_err  (frame_err)
  );

  // ---------------- prefix decoder ----------------
  kbd_state_e state_q, state_d;
  logic       emit_q, emit_d;
  kbd_evt_t   evt_q, evt_d;
  logic       is_ext_s, is_brk_s;

  assign is_ext_s = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign is_brk_s = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       hold_valid_q, hold_valid_d;
  logic [8:0] hold_key_q, hold_key_d;
  logic       hold_hit_s;

  assign hold_hit_s = hold_valid_q && (hold_key_q == {is_ext_s, rx_data_s});

  // Held-key register for typematic suppression.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hold_valid_q <= 1'b0;
      hold_key_q   <= 9'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_key_q   <= hold_key_d;
    end
  end
`endif

  // Decoder state and emitted-event registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      emit_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      emit_q  <= emit_d;
      evt_q   <= evt_d;
    end
  end

  // Prefix tracking; a non-prefix byte closes the sequence into an event.
  always_comb begin
    state_d = state_q;
    emit_d  = 1'b0;
    evt_d   = evt_q;
`ifdef KBD_TYPEMATIC_FILTER_EN
    hold_valid_d = hold_valid_q;
    hold_key_d   = hold_key_q;
`endif
    if (rx_valid_s) begin
      if (rx_data_s == PS2_EXT) begin
        state_d = ST_EXT;
      end else if (rx_data_s == PS2_BREAK) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        state_d    = ST_IDLE;
        evt_d.code = rx_data_s;
        evt_d.ext  = is_ext_s;
        evt_d.brk  = is_brk_s;
        emit_d     = 1'b1;
`ifdef KBD_TYPEMATIC_FILTER_EN
        if (!is_brk_s) begin
          if (hold_hit_s) begin
            emit_d = 1'b0;
          end else begin
            hold_valid_d = 1'b1;
            hold_key_d   = {is_ext_s, rx_data_s};
          end
        end else if (hold_hit_s) begin
          hold_valid_d = 1'b0;
        end else begin
          hold_valid_d = hold_valid_q;
        end
`endif
      end
    end else begin
      state_d = state_q;
    end
  end

  // ---------------- event FIFO ----------------
  kbd_evt_t            mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pop_s, full_s, push_ok_s;
  kbd_evt_t            head_s;

  assign full_s    = (level_q == LVL_W'(FIFO_DEPTH));
  assign evt_valid = (level_q != '0);
  // Popping only when valid means a push into an empty FIFO never bypasses.
  assign pop_s     = evt_valid && evt_ready;
  // A same-cycle pop frees the slot, so a full FIFO still takes the push.
  assign push_ok_s = emit_q && (!full_s || pop_s);

  // FIFO pointers, occupancy, overflow flag and press counter next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (emit_q && !push_ok_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    // Makes are counted when emitted, whether or not the FIFO keeps them.
    if (emit_q && !evt_q.brk) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FIFO storage and control registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= evt_q;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign head_s     = mem_q[rd_ptr_q];
  assign evt_code   = head_s.code;
  assign evt_ext    = head_s.ext;
  assign evt_break  = head_s.brk;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign press_cnt  = cnt_q;

endmodule
